// File: rtl/pipe_hazard_pkg.sv
// Package: pipe_hazard_pkg
// Shared types and helpers for the pipeline hazard controller.
//   sb_entry_t  - one scoreboard slot describing an in-flight writer
//   FWD_RF      - forwarding select value meaning "read the register file"
//   fwd_encode  - priority encoder turning a per-stage match vector into a
//                 forwarding select (youngest stage wins)
// Configuration macro consumed by users of this package: PIPE_FORWARDING_EN.
package pipe_hazard_pkg;

    // Upper bounds used to size the shared struct and helper function.
    // Narrower register indices are zero-extended into the dest field, so
    // equality compares stay exact on the real index bits.
    localparam int MAX_REG_ADDR_W = 8;
    localparam int MAX_TRACK      = 8;

    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                      valid;
        logic [MAX_REG_ADDR_W-1:0] dest;
        logic                      wb_en;
        logic                      is_load;
    } sb_entry_t;

    // Lowest set bit k returns k+1; no bit set returns FWD_RF.
    function automatic logic [7:0] fwd_encode(input logic [MAX_TRACK-1:0] match);
        logic [7:0] sel;
        sel = 8'(FWD_RF);
        for (int k = MAX_TRACK - 1; k >= 0; k--) begin
            if (match[k]) sel = 8'(k + 1);
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Module: hazard_scoreboard
// Shift register of in-flight writers, one slot per pipeline stage after ID
// (entry 0 = EXE, entry 1 = MEM, ...).
// Ports:
//   clk, rst        - clock, synchronous active-high reset (clears every slot)
//   hold            - freeze all slots (back end stalled)
//   insert_invalid  - shift, but load an empty slot instead of new_entry
//   new_entry       - descriptor of the instruction leaving ID
//   entries         - current slot contents, entries[0] is the youngest
module hazard_scoreboard
    import pipe_hazard_pkg::*;
#(
    parameter int N_TRACK = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold,
    input  logic                    insert_invalid,
    input  sb_entry_t               new_entry,
    output sb_entry_t [N_TRACK-1:0] entries
);

    always_ff @(posedge clk) begin
        if (rst) begin
            entries <= '0;
        end else if (!hold) begin
            entries[0] <= insert_invalid ? sb_entry_t'('0) : new_entry;
            for (int k = 1; k < N_TRACK; k++) begin
                entries[k] <= entries[k-1];
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Module: pipe_hazard_ctrl
// Central pipeline control beside the ID stage. Compares the ID sources
// against the in-flight writer scoreboard and merges data-memory wait,
// taken-branch flush and RAW hazard stalls into one set of controls.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   id_valid, id_src1, id_src2, - ID instruction descriptor; id_valid
//   id_two_src, id_dest,          qualifies all other id_* fields (there is
//   id_wb_en, id_mem_rd           no other handshake: stall_if_id is the
//                                 only back-pressure towards ID)
//   exe_br_taken                - branch resolved taken in EXE
//   mem_busy                    - data memory not ready this cycle
//   stall_if_id, bubble_id_exe, - pipeline register controls
//   flush_if_id, stall_back
//   fwd_sel1, fwd_sel2          - operand source (0 = register file,
//                                 k+1 = scoreboard entry k)
//   stall_cycles                - saturating hazard stall counter
// Configuration: define PIPE_FORWARDING_EN to enable forwarding; hazards
// then reduce to load-use on entry 0. Without it any in-flight match stalls.
// All outputs are combinational on current state and inputs, forced to 0
// while rst is high.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter  int REG_ADDR_W = 4,
    parameter  int N_TRACK    = 2,
    parameter  int CNT_W      = 16,
    localparam int FSW        = $clog2(N_TRACK + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_rd,
    input  logic                  exe_br_taken,
    input  logic                  mem_busy,
    output logic                  stall_if_id,
    output logic                  bubble_id_exe,
    output logic                  flush_if_id,
    output logic                  stall_back,
    output logic [FSW-1:0]        fwd_sel1,
    output logic [FSW-1:0]        fwd_sel2,
    output logic [CNT_W-1:0]      stall_cycles
);

    sb_entry_t [N_TRACK-1:0]   entries;
    sb_entry_t                 new_entry;
    logic [MAX_REG_ADDR_W-1:0] src1_x;
    logic [MAX_REG_ADDR_W-1:0] src2_x;
    logic [N_TRACK-1:0]        m1;
    logic [N_TRACK-1:0]        m2;
    logic [N_TRACK-1:0]        load_vec;
    logic                      hazard;
    logic                      hold;
    logic                      ins_inv;
    logic                      cnt_inc;
    logic                      stall_c;
    logic                      bubble_c;
    logic                      flush_c;
    logic                      back_c;
    logic [FSW-1:0]            fwd1_c;
    logic [FSW-1:0]            fwd2_c;
    logic [CNT_W-1:0]          cnt_q;
    logic                      sb_unused;

    assign src1_x = MAX_REG_ADDR_W'(id_src1);
    assign src2_x = MAX_REG_ADDR_W'(id_src2);

    assign new_entry.valid   = id_valid;
    assign new_entry.dest    = MAX_REG_ADDR_W'(id_dest);
    assign new_entry.wb_en   = id_wb_en;
    assign new_entry.is_load = id_mem_rd;

    hazard_scoreboard #(
        .N_TRACK (N_TRACK)
    ) u_sb (
        .clk            (clk),
        .rst            (rst),
        .hold           (hold),
        .insert_invalid (ins_inv),
        .new_entry      (new_entry),
        .entries        (entries)
    );

    // Per-stage source matches; m1 | m2 is hit(k).
    always_comb begin
        m1       = '0;
        m2       = '0;
        load_vec = '0;
        for (int k = 0; k < N_TRACK; k++) begin
            m1[k] = id_valid & entries[k].valid & entries[k].wb_en &
                    (entries[k].dest == src1_x);
            m2[k] = id_valid & entries[k].valid & entries[k].wb_en &
                    id_two_src & (entries[k].dest == src2_x);
            load_vec[k] = entries[k].is_load;
        end
    end

    // Older load flags are informational only; keep them referenced.
    assign sb_unused = ^load_vec;

`ifdef PIPE_FORWARDING_EN
    // Only a load sitting in EXE cannot be forwarded in time.
    assign hazard = (m1[0] | m2[0]) & load_vec[0];
    assign fwd1_c = FSW'(fwd_encode(MAX_TRACK'(m1)));
    assign fwd2_c = FSW'(fwd_encode(MAX_TRACK'(m2)));
`else
    assign hazard = |(m1 | m2);
    assign fwd1_c = FSW'(FWD_RF);
    assign fwd2_c = FSW'(FWD_RF);
`endif

    // Priority: mem_busy > exe_br_taken > hazard > normal issue.
    // While memory is busy EXE is frozen and will re-present its branch,
    // so the branch is ignored and the scoreboard holds.
    always_comb begin
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        back_c   = 1'b0;
        hold     = 1'b0;
        ins_inv  = 1'b0;
        cnt_inc  = 1'b0;
        if (mem_busy) begin
            stall_c = 1'b1;
            back_c  = 1'b1;
            hold    = 1'b1;
        end else if (exe_br_taken) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            ins_inv  = 1'b1;
        end else if (hazard) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            ins_inv  = 1'b1;
            cnt_inc  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_if_id   = ~rst & stall_c;
    assign bubble_id_exe = ~rst & bubble_c;
    assign flush_if_id   = ~rst & flush_c;
    assign stall_back    = ~rst & back_c;
    assign fwd_sel1      = rst ? '0 : fwd1_c;
    assign fwd_sel2      = rst ? '0 : fwd2_c;
    assign stall_cycles  = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl. Expectations follow the default build
// unless PIPE_FORWARDING_EN is defined for the bench as well.
module tb_pipe_hazard_ctrl;

    localparam int FSW = 2;
    localparam int OW  = 4 + 2 * FSW + 16;

    typedef struct packed {
        logic       rst;
        logic       v;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       two;
        logic [3:0] d;
        logic       wb;
        logic       ld;
        logic       br;
        logic       busy;
    } stim_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       id_valid, id_two_src, id_wb_en, id_mem_rd, exe_br_taken, mem_busy;
    logic [3:0] id_src1, id_src2, id_dest;

    logic           stall_if_id, bubble_id_exe, flush_if_id, stall_back;
    logic [FSW-1:0] fwd_sel1, fwd_sel2;
    logic [15:0]    stall_cycles;

    logic           c2_stall_if_id, c2_bubble_id_exe, c2_flush_if_id, c2_stall_back;
    logic [FSW-1:0] c2_fwd_sel1, c2_fwd_sel2;
    logic [1:0]     c2_stall_cycles;

    logic [OW-1:0] dut_out;
    assign dut_out = {stall_if_id, bubble_id_exe, flush_if_id, stall_back,
                      fwd_sel1, fwd_sel2, stall_cycles};

    pipe_hazard_ctrl #(.REG_ADDR_W(4), .N_TRACK(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
        .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_rd(id_mem_rd), .exe_br_taken(exe_br_taken),
        .mem_busy(mem_busy), .stall_if_id(stall_if_id), .bubble_id_exe(bubble_id_exe),
        .flush_if_id(flush_if_id), .stall_back(stall_back), .fwd_sel1(fwd_sel1),
        .fwd_sel2(fwd_sel2), .stall_cycles(stall_cycles)
    );

    pipe_hazard_ctrl #(.REG_ADDR_W(4), .N_TRACK(2), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
        .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_rd(id_mem_rd), .exe_br_taken(exe_br_taken),
        .mem_busy(mem_busy), .stall_if_id(c2_stall_if_id), .bubble_id_exe(c2_bubble_id_exe),
        .flush_if_id(c2_flush_if_id), .stall_back(c2_stall_back), .fwd_sel1(c2_fwd_sel1),
        .fwd_sel2(c2_fwd_sel2), .stall_cycles(c2_stall_cycles)
    );

    // ---------------- scoreboard ----------------
    logic [OW-1:0] exp_q[$];
    logic [1:0]    exp2_q[$];
    int vectors     = 0;
    int miscompares = 0;

`ifdef PIPE_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    function automatic stim_t ins(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                                  input logic two, input logic [3:0] d, input logic wb,
                                  input logic ld);
        stim_t s;
        s = '0;
        s.v = v; s.s1 = s1; s.s2 = s2; s.two = two; s.d = d; s.wb = wb; s.ld = ld;
        return s;
    endfunction

    function automatic logic [OW-1:0] outv(input logic st, input logic bub, input logic fl,
                                           input logic sb, input logic [1:0] f1,
                                           input logic [1:0] f2, input logic [15:0] c);
        return {st, bub, fl, sb, f1, f2, c};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input stim_t s);
        rst          = s.rst;
        id_valid     = s.v;
        id_src1      = s.s1;
        id_src2      = s.s2;
        id_two_src   = s.two;
        id_dest      = s.d;
        id_wb_en     = s.wb;
        id_mem_rd    = s.ld;
        exe_br_taken = s.br;
        mem_busy     = s.busy;
    endtask

    // Common instructions: LDR r4 and a consumer reading r4 twice.
    stim_t ldr_r4, use_r4, idle_i, rst_i;
    initial begin
        ldr_r4 = ins(1, 4'd2, 4'd0, 0, 4'd4, 1, 1);
        use_r4 = ins(1, 4'd4, 4'd4, 1, 4'd5, 1, 0);
        idle_i = ins(0, 4'd0, 4'd0, 0, 4'd0, 0, 0);
        rst_i  = idle_i;
        rst_i.rst = 1'b1;
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        stim_t s[$];
        logic [OW-1:0] e[$];
        stim_t t;
        logic [OW-1:0] got, want;
        // ADD r0 enters the scoreboard, then reset hits while a hazard,
        // a branch and a memory wait are all present.
        s.push_back(ins(1, 4'd5, 4'd6, 1, 4'd0, 1, 0)); e.push_back(outv(0,0,0,0,0,0,0));
        t = ins(1, 4'd0, 4'd0, 0, 4'd3, 1, 0); t.rst = 1; t.br = 1; t.busy = 1;
        s.push_back(t); e.push_back(outv(0,0,0,0,0,0,0));
        s.push_back(ins(1, 4'd0, 4'd0, 1, 4'd3, 0, 0)); e.push_back(outv(0,0,0,0,0,0,0));
        s.push_back(ins(1, 4'd3, 4'd0, 0, 4'd8, 0, 0)); e.push_back(outv(0,0,0,0,0,0,0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = dut_out;
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset[%0d]: got %h want %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_raw();
        stim_t s[$];
        logic [OW-1:0] e[$];
        logic [OW-1:0] got, want;
        stim_t add_r1, sub_r2;
        add_r1 = ins(1, 4'd8, 4'd9, 1, 4'd1, 1, 0);
        sub_r2 = ins(1, 4'd1, 4'd3, 1, 4'd2, 1, 0);
        s.push_back(rst_i);  e.push_back(outv(0,0,0,0,0,0,0));
        s.push_back(add_r1); e.push_back(outv(0,0,0,0,0,0,0));
        if (!FWD) begin
            s.push_back(sub_r2); e.push_back(outv(1,1,0,0,0,0,0));
            s.push_back(sub_r2); e.push_back(outv(1,1,0,0,0,0,1));
            s.push_back(sub_r2); e.push_back(outv(0,0,0,0,0,0,2));
            s.push_back(idle_i); e.push_back(outv(0,0,0,0,0,0,2));
        end else begin
            s.push_back(sub_r2); e.push_back(outv(0,0,0,0,1,0,0));
            s.push_back(add_r1); e.push_back(outv(0,0,0,0,0,0,0));
            s.push_back(ins(1, 4'd8, 4'd9, 1, 4'd6, 1, 0)); e.push_back(outv(0,0,0,0,0,0,0));
            s.push_back(sub_r2); e.push_back(outv(0,0,0,0,2,0,0));
            s.push_back(ins(1, 4'd8, 4'd9, 1, 4'd2, 1, 0)); e.push_back(outv(0,0,0,0,0,0,0));
            // r2 written by both EXE and MEM: youngest wins.
            s.push_back(ins(1, 4'd2, 4'd2, 1, 4'd10, 1, 0)); e.push_back(outv(0,0,0,0,1,1,0));
        end
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = dut_out;
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL raw[%0d]: got %h want %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_src_qualify();
        stim_t s[$];
        logic [OW-1:0] e[$];
        logic [OW-1:0] got, want;
        stim_t e3;
        e3 = ins(1, 4'd7, 4'd0, 0, 4'd9, 1, 0);
        s.push_back(rst_i); e.push_back(outv(0,0,0,0,0,0,0));
        s.push_back(ins(1, 4'd8, 4'd9, 1, 4'd7, 1, 0)); e.push_back(outv(0,0,0,0,0,0,0));
        // src2 matches but is not read; the instruction itself does not write back.
        s.push_back(ins(1, 4'd5, 4'd7, 0, 4'd7, 0, 0)); e.push_back(outv(0,0,0,0,0,0,0));
        if (!FWD) begin
            s.push_back(e3); e.push_back(outv(1,1,0,0,0,0,0));
            s.push_back(e3); e.push_back(outv(0,0,0,0,0,0,1));
            s.push_back(ins(0, 4'd9, 4'd0, 0, 4'd0, 0, 0)); e.push_back(outv(0,0,0,0,0,0,1));
        end else begin
            s.push_back(e3); e.push_back(outv(0,0,0,0,2,0,0));
            s.push_back(ins(0, 4'd9, 4'd0, 0, 4'd0, 0, 0)); e.push_back(outv(0,0,0,0,0,0,0));
            s.push_back(idle_i); e.push_back(outv(0,0,0,0,0,0,0));
        end
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = dut_out;
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL src_qualify[%0d]: got %h want %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        logic [OW-1:0] e[$];
        logic [OW-1:0] got, want;
        s.push_back(rst_i);  e.push_back(outv(0,0,0,0,0,0,0));
        s.push_back(ldr_r4); e.push_back(outv(0,0,0,0,0,0,0));
        if (!FWD) begin
            s.push_back(use_r4); e.push_back(outv(1,1,0,0,0,0,0));
            s.push_back(use_r4); e.push_back(outv(1,1,0,0,0,0,1));
            s.push_back(use_r4); e.push_back(outv(0,0,0,0,0,0,2));
        end else begin
            s.push_back(use_r4); e.push_back(outv(1,1,0,0,1,1,0));
            s.push_back(use_r4); e.push_back(outv(0,0,0,0,2,2,1));
            s.push_back(idle_i); e.push_back(outv(0,0,0,0,0,0,1));
        end
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = dut_out;
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL load_use[%0d]: got %h want %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        stim_t s[$];
        logic [OW-1:0] e[$];
        logic [OW-1:0] got, want;
        stim_t t;
        logic [1:0] f;
        f = FWD ? 2'd1 : 2'd0;
        s.push_back(rst_i);  e.push_back(outv(0,0,0,0,0,0,0));
        s.push_back(ldr_r4); e.push_back(outv(0,0,0,0,0,0,0));
        t = use_r4; t.br = 1;
        s.push_back(t); e.push_back(outv(0,1,1,0,f,f,0));
        s.push_back(use_r4);
        if (!FWD) e.push_back(outv(1,1,0,0,0,0,0));
        else      e.push_back(outv(0,0,0,0,2,2,0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = dut_out;
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL branch[%0d]: got %h want %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_busy();
        stim_t s[$];
        logic [OW-1:0] e[$];
        logic [OW-1:0] got, want;
        stim_t t;
        logic [1:0] f;
        f = FWD ? 2'd1 : 2'd0;
        s.push_back(rst_i);  e.push_back(outv(0,0,0,0,0,0,0));
        s.push_back(ldr_r4); e.push_back(outv(0,0,0,0,0,0,0));
        t = use_r4; t.br = 1; t.busy = 1;
        for (int k = 0; k < 3; k++) begin
            s.push_back(t); e.push_back(outv(1,0,0,1,f,f,0));
        end
        t.busy = 0;
        s.push_back(t); e.push_back(outv(0,1,1,0,f,f,0));
        // The load must still be tracked after the frozen cycles.
        s.push_back(use_r4);
        if (!FWD) e.push_back(outv(1,1,0,0,0,0,0));
        else      e.push_back(outv(0,0,0,0,2,2,0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            got  = dut_out;
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL mem_busy[%0d]: got %h want %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturate();
        stim_t s[$];
        logic [OW-1:0] e[$];
        logic [1:0] e2[$];
        logic [OW-1:0] got, want;
        logic [1:0] got2, want2;
        stim_t t;
        logic [1:0] f;
        f = FWD ? 2'd1 : 2'd0;
        s.push_back(rst_i); e.push_back(outv(0,0,0,0,0,0,0)); e2.push_back(2'd0);
        // Alternating load / consumer gives one hazard cycle per pair.
        for (int j = 0; j < 5; j++) begin
            s.push_back(ldr_r4); e.push_back(outv(0,0,0,0,0,0,16'(j)));
            e2.push_back((j > 3) ? 2'd3 : 2'(j));
            s.push_back(use_r4); e.push_back(outv(1,1,0,0,f,f,16'(j)));
            e2.push_back((j > 3) ? 2'd3 : 2'(j));
        end
        s.push_back(idle_i); e.push_back(outv(0,0,0,0,0,0,5)); e2.push_back(2'd3);
        s.push_back(ldr_r4); e.push_back(outv(0,0,0,0,0,0,5)); e2.push_back(2'd3);
        t = use_r4; t.rst = 1;
        s.push_back(t); e.push_back(outv(0,0,0,0,0,0,0)); e2.push_back(2'd0);
        s.push_back(use_r4); e.push_back(outv(0,0,0,0,0,0,0)); e2.push_back(2'd0);
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(e[i]);
            exp2_q.push_back(e2[i]);
            @(negedge clk);
            want  = exp_q.pop_front();
            want2 = exp2_q.pop_front();
            got   = dut_out;
            got2  = c2_stall_cycles;
            vectors += 2;
            if (got !== want) begin
                miscompares++;
                $display("FAIL saturate[%0d]: got %h want %h", i, got, want);
            end
            if (got2 !== want2) begin
                miscompares++;
                $display("FAIL saturate_cnt2[%0d]: got %0d want %0d", i, got2, want2);
            end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        #2;
        drive(rst_i);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_raw();
        test_src_qualify();
        test_load_use();
        test_branch();
        test_mem_busy();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
